// File: rtl/keypad_pkg.sv
// Shared types and widths for the 4x4 keypad scan controller.
package keypad_pkg;

    localparam int COL_W = 2;
    localparam int ROW_W = 2;
    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        PRESS   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Key codes are {column, row}, matching the decoder/encoder pin order.
    function automatic logic [KEY_W-1:0] pack_key(input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key handoff from the scan controller to the keyboard-to-BCD stage.
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving from outside the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanning, debounce and one-code-per-press handoff for the 4x4 keypad.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [COL_W-1:0]     col_sel,
    input  logic [ROW_W-1:0]     row_code,
    input  logic                 row_hit,
    keypad_scan_ctrl_if.master   key_if
);

    localparam int         DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    logic [ROW_W-1:0] rc_s;
    logic             rh_s;

    sync_2ff #(.WIDTH(ROW_W + 1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({row_hit, row_code}),
        .q     ({rh_s, rc_s})
    );

    state_t           state_reg, state_next;
    logic [DW-1:0]    dcnt_reg, dcnt_next;
    logic [3:0]       bcnt_reg, bcnt_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [KEY_W-1:0] cand_reg, cand_next;
    logic [KEY_W-1:0] code_reg, code_next;
    logic             valid_reg, valid_next;
    logic             sample;
    logic [3:0]       bcnt_inc;

    // The dwell counter free-runs in every state so sample points keep a fixed phase.
    assign sample   = (dcnt_reg == DW'(SCAN_DIV - 1));
    assign bcnt_inc = bcnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        cand_next  = cand_reg;
        bcnt_next  = bcnt_reg;
        code_next  = code_reg;
        valid_next = valid_reg;
        dcnt_next  = sample ? '0 : dcnt_reg + 1'b1;

        case (state_reg)
            SCAN: begin
                if (sample) begin
                    if (rh_s) begin
                        cand_next  = pack_key(col_reg, rc_s);
                        bcnt_next  = '0;
                        state_next = CONFIRM;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            CONFIRM: begin
                if (sample) begin
                    if (rh_s && (rc_s == cand_reg[ROW_W-1:0])) begin
                        bcnt_next = bcnt_inc;
                        if (bcnt_inc == DEB) begin
                            code_next  = cand_reg;
                            valid_next = 1'b1;
                            state_next = PRESS;
                        end
                    end else begin
                        state_next = SCAN;
                        col_next   = col_reg + 1'b1;
                    end
                end
            end
            PRESS: begin
                // A release while waiting here is ignored; the key is already owed downstream.
                if (key_if.key_ready) begin
                    valid_next = 1'b0;
                    bcnt_next  = '0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (sample) begin
                    if (!rh_s) begin
                        bcnt_next = bcnt_inc;
                        if (bcnt_inc == DEB) begin
                            state_next = SCAN;
                            col_next   = col_reg + 1'b1;
                        end
                    end else begin
                        bcnt_next = '0;
                    end
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SCAN;
            dcnt_reg  <= '0;
            bcnt_reg  <= '0;
            col_reg   <= '0;
            cand_reg  <= '0;
            code_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dcnt_reg  <= dcnt_next;
            bcnt_reg  <= bcnt_next;
            col_reg   <= col_next;
            cand_reg  <= cand_next;
            code_reg  <= code_next;
            valid_reg <= valid_next;
        end
    end

    assign col_sel          = col_reg;
    assign key_if.key_code  = code_reg;
    assign key_if.key_valid = valid_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad pin model plus a timing model derived from the scan/debounce rules.
module tb_keypad_scan_ctrl;

    localparam int S = 4;
    localparam int D = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] col_sel;
    logic [1:0] row_code;
    logic       row_hit;
    logic [15:0] pressed;
    logic [3:0]  row_sel;

    int cyc = 0;
    int rst_cyc = 0;
    int base_col = 0;
    int base_cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int txn = 0;

    keypad_scan_ctrl_if key_if ();

    keypad_scan_ctrl #(.SCAN_DIV(S), .DEBOUNCE(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_sel  (col_sel),
        .row_code (row_code),
        .row_hit  (row_hit),
        .key_if   (key_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix + encoder: OE only when exactly one row of the driven column is closed.
    assign row_sel = pressed[{col_sel, 2'b00} +: 4];
    always_comb begin
        row_hit  = ($countones(row_sel) == 1);
        row_code = 2'd0;
        for (int i = 0; i < 4; i++)
            if (row_sel[i]) row_code = 2'(i);
    end

    function automatic int now();
        return cyc - rst_cyc;
    endfunction

    // Idle scanning: the column advances at every multiple of S cycles after base_cyc.
    function automatic int model_col(input int t);
        return (base_col + (t - base_cyc) / S) % 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @t=%0d: got %0h expected %0h", tag, now(), got, exp);
    endtask

    task automatic run_idle(input int t_end);
        while (now() < t_end) begin
            @(negedge clk);
            chk("idle_col", 32'(col_sel), 32'(model_col(now())));
            chk("idle_valid", 32'(key_if.key_valid), 32'd0);
        end
    endtask

    task automatic run_frozen(input int t_end, input int c, input logic v, input int code);
        while (now() < t_end) begin
            @(negedge clk);
            chk("frozen_col", 32'(col_sel), 32'(c));
            chk("frozen_valid", 32'(key_if.key_valid), 32'(v));
            if (v) chk("key_code", 32'(key_if.key_code), 32'(code));
        end
    endtask

    // First sample edge at or after n+3 (two sync flops) where column c is being driven.
    function automatic int capture_edge(input int n, input int c);
        int e;
        e = (n / S + 1) * S;
        for (int k = 0; k < 12; k++) begin
            if (model_col(e - 1) == c && e >= n + 3) break;
            e += S;
        end
        return e;
    endfunction

    task automatic do_press(input int c, input int r, input int rdly, input bit early);
        int e, rise, h, t_rel, e1, adv, code;
        bit released;
        code = c * 4 + r;
        e = capture_edge(now(), c);
        rise = e + D * S;
        pressed[code] = 1'b1;
        run_idle(e - 1);
        key_if.key_ready = (rdly == 0);
        run_frozen(rise - 1, c, 1'b0, 0);
        run_frozen(rise, c, 1'b1, code);
        released = 1'b0;
        t_rel = 0;
        for (int k = 0; k < rdly; k++) begin
            if (early && k == rdly / 2) begin
                pressed[code] = 1'b0;
                released = 1'b1;
                t_rel = now();
            end
            run_frozen(now() + 1, c, 1'b1, code);
        end
        key_if.key_ready = 1'b1;
        h = now() + 1;
        run_frozen(h, c, 1'b0, 0);
        key_if.key_ready = 1'($urandom_range(0, 1));
        if (!released) begin
            run_frozen(h + int'($urandom_range(0, 6)), c, 1'b0, 0);
            pressed[code] = 1'b0;
            t_rel = now();
        end
        e1 = (h + 1 > t_rel + 3) ? h + 1 : t_rel + 3;
        e1 = ((e1 + S - 1) / S) * S;
        adv = e1 + (D - 1) * S;
        run_frozen(adv - 1, c, 1'b0, 0);
        base_col = (c + 1) % 4;
        base_cyc = adv;
        run_idle(adv);
        $display("txn %0d: press col=%0d row=%0d code=%h rdly=%0d early=%0d rise=%0d adv=%0d",
                 txn, c, r, code, rdly, early, rise, adv);
        txn++;
    endtask

    initial begin
        int e, c;
        rst_n = 1'b0;
        pressed = '0;
        key_if.key_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col_sel), 32'd0);
        chk("rst_valid", 32'(key_if.key_valid), 32'd0);
        chk("rst_code", 32'(key_if.key_code), 32'd0);
        rst_n = 1'b1;
        rst_cyc = cyc;
        base_col = 0;
        base_cyc = 0;
        run_idle(20);
        $display("txn %0d: idle scan after reset", txn++);

        do_press(2, 1, 0, 1'b0);
        do_press(2, 1, 50, 1'b1);

        // Bounce: one agreeing capture sample, then the contact opens.
        e = capture_edge(now(), 1);
        pressed[7] = 1'b1;
        run_idle(e - 1);
        run_frozen(e, 1, 1'b0, 0);
        pressed[7] = 1'b0;
        run_frozen(e + S - 1, 1, 1'b0, 0);
        base_col = 2;
        base_cyc = e + S;
        run_idle(e + S + 12);
        $display("txn %0d: bounce col=1 row=3", txn++);

        // Reset asserted while confirming a press.
        e = capture_edge(now(), 3);
        pressed[14] = 1'b1;
        run_idle(e - 1);
        run_frozen(e + 1, 3, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_col", 32'(col_sel), 32'd0);
        chk("abort_valid", 32'(key_if.key_valid), 32'd0);
        chk("abort_code", 32'(key_if.key_code), 32'd0);
        pressed = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst_cyc = cyc;
        base_col = 0;
        base_cyc = 0;
        run_idle(24);
        $display("txn %0d: reset during confirm", txn++);

        // Two rows in one column: encoder drops OE, scanning must not stop.
        c = int'($urandom_range(0, 3));
        pressed[c * 4 + 0] = 1'b1;
        pressed[c * 4 + 2] = 1'b1;
        run_idle(now() + 40);
        pressed = '0;
        run_idle(now() + 8);
        $display("txn %0d: two rows in col=%0d", txn++, c);

        for (int k = 0; k < 10; k++) begin
            run_idle(now() + int'($urandom_range(0, 9)));
            do_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
